// File: rtl/arc_mem_pkg.sv
// Shared types and width defaults for the ARC memory master.
// Holds the FSM state encoding and the default address/data widths.
// No logic; imported by arc_mem_master.
package arc_mem_pkg;

  localparam int ARC_AW = 32;
  localparam int ARC_DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arc_state_e;

endpackage

// File: rtl/arc_mem_master.sv
// Purpose : single-outstanding bus initiator from the ARC core to main_memory.
// Latency : read = accept + 2 + RD_LATENCY cycles to rsp_valid (3 at RD_LATENCY=1); write = accept + 2.
// Backpressure: req_ready only in IDLE; rsp_valid and its data are held until rsp_ready.
//
// Ports:
//   clk, reset          : clock, async active-high reset
//   req_*               : core request handshake (valid/ready, write, addr, wdata)
//   rsp_*               : core response handshake (valid/ready, rdata, err)
//   address, data_in    : registered pins to main_memory, hold value between requests
//   rd, wr              : one-cycle strobes to main_memory, decoded from state
//   mem_data_out        : read data from main_memory
//
// Optional feature: ARC_MEM_ALIGN_CHECK_EN -- when defined, a request whose
// req_addr[1:0] is nonzero is accepted but answered directly with rsp_err=1,
// without touching memory. When undefined, rsp_err is tied low.
module arc_mem_master
  import arc_mem_pkg::*;
#(
  parameter int AW         = ARC_AW,
  parameter int DW         = ARC_DW,
  parameter int RD_LATENCY = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] address,
  output logic [DW-1:0] data_in,
  output logic          rd,
  output logic          wr,
  input  logic [DW-1:0] mem_data_out
);

  localparam int CW = $clog2(RD_LATENCY + 1);

  arc_state_e    state_q, state_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          write_q, write_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;
`ifdef ARC_MEM_ALIGN_CHECK_EN
  logic          err_q,   err_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
`ifdef ARC_MEM_ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
`ifdef ARC_MEM_ALIGN_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
`ifdef ARC_MEM_ALIGN_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
`ifdef ARC_MEM_ALIGN_CHECK_EN
          if (req_addr[1:0] != 2'b00) begin
            // Misaligned: answer at once; memory pins keep their old value.
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            state_d = ISSUE;
          end
`else
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = ISSUE;
`endif
        end
      end
      ISSUE: begin
        if (write_q) begin
          rdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d   = CW'(RD_LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        // cnt is only loaded in ISSUE, so it never wraps below 1 here.
        if (cnt_q == CW'(1)) begin
          rdata_d = mem_data_out;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode from the async-reset state, so reset kills them instantly.
  assign rd        = (state_q == ISSUE) && !write_q;
  assign wr        = (state_q == ISSUE) &&  write_q;
  assign req_ready = (state_q == IDLE)  && !reset;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign address   = addr_q;
  assign data_in   = wdata_q;
`ifdef ARC_MEM_ALIGN_CHECK_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_arc_mem_master.sv
// Directed bench for arc_mem_master with a registered-read memory model.
// Latency: memory returns data one cycle after rd.
// Backpressure: bench drives rsp_ready and holds it low where required.
module tb_arc_mem_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] address, data_in, mem_data_out;
  logic        rd, wr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arc_mem_master #(.AW(32), .DW(32), .RD_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .address(address), .data_in(data_in), .rd(rd), .wr(wr),
    .mem_data_out(mem_data_out)
  );

  // main_memory model: word-addressed by the byte address, registered read.
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (reset) begin
      mem[2092] <= 32'h00000014;
      mem[2096] <= 32'h00000834;
    end else begin
      if (wr) mem[address[11:0]] <= data_in;
      if (rd) mem_data_out <= mem[address[11:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One request from IDLE; rsp_ready held low for 'hold' cycles after rsp_valid.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input int hold, output int lat, output int nrd, output int nwr,
                      output logic [31:0] pin_a, output logic [31:0] pin_d,
                      output logic [31:0] rdata, output logic err, output int unstable);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    lat = 0; nrd = 0; nwr = 0; unstable = 0; pin_a = '0; pin_d = '0;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      if (rd) nrd++;
      if (wr) nwr++;
      if (rd || wr) begin pin_a = address; pin_d = data_in; end
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== rdata || req_ready || rd || wr) unstable++;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  int          lat, nrd, nwr, unst, late;
  logic [31:0] pa, pd, rdat;
  logic        err;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_rd_wr",     {30'b0, rd, wr}, 32'd0);
    check("rst_rsp",       {30'b0, rsp_valid, rsp_err}, 32'd0);
    check("rst_rdata",     rsp_rdata, 32'd0);
    check("rst_address",   address, 32'd0);
    check("rst_data_in",   data_in, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_req_ready", {31'b0, req_ready}, 32'd1);

    // 1: read 2092
    xact(1'b0, 32'd2092, 32'd0, 0, lat, nrd, nwr, pa, pd, rdat, err, unst);
    check("rd1_lat",   lat, 32'd3);
    check("rd1_nrd",   nrd, 32'd1);
    check("rd1_nwr",   nwr, 32'd0);
    check("rd1_addr",  pa, 32'd2092);
    check("rd1_rdata", rdat, 32'h00000014);
    check("rd1_err",   {31'b0, err}, 32'd0);
    check("rd1_after_valid", {31'b0, rsp_valid}, 32'd0);
    check("rd1_after_ready", {31'b0, req_ready}, 32'd1);
    check("rd1_addr_hold", address, 32'd2092);

    // 2: write 2100 then read it back
    xact(1'b1, 32'd2100, 32'hDEADBEEF, 0, lat, nrd, nwr, pa, pd, rdat, err, unst);
    check("wr_lat",   lat, 32'd2);
    check("wr_nwr",   nwr, 32'd1);
    check("wr_nrd",   nrd, 32'd0);
    check("wr_addr",  pa, 32'd2100);
    check("wr_data",  pd, 32'hDEADBEEF);
    check("wr_rdata", rdat, 32'd0);
    xact(1'b0, 32'd2100, 32'd0, 0, lat, nrd, nwr, pa, pd, rdat, err, unst);
    check("rb_lat",   lat, 32'd3);
    check("rb_rdata", rdat, 32'hDEADBEEF);

    // 3: read 2096 with rsp_ready held low for 5 cycles
    xact(1'b0, 32'd2096, 32'd0, 5, lat, nrd, nwr, pa, pd, rdat, err, unst);
    check("hold_rdata",    rdat, 32'h00000834);
    check("hold_unstable", unst, 32'd0);
    check("hold_release",  {31'b0, rsp_valid}, 32'd0);

    // 4a: reset during ISSUE drops rd at once
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd2092;
    @(negedge clk);
    req_valid = 1'b0;
    check("rsti_rd_before", {31'b0, rd}, 32'd1);
    reset = 1'b1;
    #1;
    check("rsti_rd_after", {30'b0, rd, wr}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 4b: reset during WAIT
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd2096;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstw_pins",  {29'b0, rd, wr, rsp_valid}, 32'd0);
    check("rstw_ready", {31'b0, req_ready}, 32'd0);
    check("rstw_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rstw_ready_rel", {31'b0, req_ready}, 32'd1);
    late = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid || rd || wr) late++;
    end
    check("rstw_no_stale", late, 32'd0);

    // 5: misaligned read 2093
    xact(1'b0, 32'd2093, 32'd0, 0, lat, nrd, nwr, pa, pd, rdat, err, unst);
`ifdef ARC_MEM_ALIGN_CHECK_EN
    check("mis_lat",   lat, 32'd1);
    check("mis_pulse", nrd + nwr, 32'd0);
    check("mis_err",   {31'b0, err}, 32'd1);
    check("mis_rdata", rdat, 32'd0);
`else
    check("mis_lat",   lat, 32'd3);
    check("mis_nrd",   nrd, 32'd1);
    check("mis_addr",  pa, 32'd2093);
    check("mis_err",   {31'b0, err}, 32'd0);
`endif

    // 6: back-to-back reads with req_valid held
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd2092;
    @(negedge clk);
    req_addr = 32'd2096;
    check("b2b_rd1", {31'b0, rd}, 32'd1);
    check("b2b_addr1", address, 32'd2092);
    @(negedge clk);
    @(negedge clk);
    check("b2b_v1",     {31'b0, rsp_valid}, 32'd1);
    check("b2b_data1",  rsp_rdata, 32'h00000014);
    check("b2b_busy",   {31'b0, req_ready}, 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("b2b_idle_ready", {31'b0, req_ready}, 32'd1);
    check("b2b_idle_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_rd2",   {31'b0, rd}, 32'd1);
    check("b2b_addr2", address, 32'd2096);
    @(negedge clk);
    @(negedge clk);
    check("b2b_v2",    {31'b0, rsp_valid}, 32'd1);
    check("b2b_data2", rsp_rdata, 32'h00000834);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("b2b_done", {31'b0, rsp_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
